// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared definitions for the RV32M multiply/divide unit.
//   - MULDIV_OP_* : funct3 encodings of the eight M-extension ops
//   - muldiv_state_e : control FSM state encoding (IDLE must stay zero)
//   - muldiv_iters() : divide iteration count for a given width and radix
package muldiv_unit_pkg;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL      = 3'd1,
        ST_DIV_ITER = 3'd2,
        ST_DIV_FIX  = 3'd3,
        ST_DONE     = 3'd4,
        ST_WAIT_LOW = 3'd5
    } muldiv_state_e;

    // ITER = XLEN / DIV_BITS_PER_CYCLE
    function automatic int muldiv_iters(input int xlen, input int bpc);
        return xlen / bpc;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_radix_step.sv
// muldiv_unit_div_radix_step: one combinational restoring-division step that
// retires BPC quotient bits.
//   rem_i     : partial remainder (always < divisor_i on entry)
//   bits_i    : next BPC dividend bits, MSB first
//   divisor_i : divisor magnitude
//   rem_o     : partial remainder after BPC shift/subtract rounds
//   q_o       : BPC quotient bits produced, MSB first
module muldiv_unit_div_radix_step #(
    parameter int XLEN = 32,
    parameter int BPC  = 1
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [BPC-1:0]  bits_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [BPC-1:0]  q_o
);

    // One extra bit holds the shifted-out MSB so the compare sees the full value.
    logic [XLEN:0] r;

    always_comb begin
        r   = {1'b0, rem_i};
        q_o = '0;
        for (int i = BPC - 1; i >= 0; i--) begin
            r = {r[XLEN-1:0], bits_i[i]};
            if (r >= {1'b0, divisor_i}) begin
                r      = r - {1'b0, divisor_i};
                q_o[i] = 1'b1;
            end
        end
        rem_o = r[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit with valid/ready handshake.
//   clk, resetn        : clock, asynchronous active-low reset
//   valid, op, rs1, rs2: request; operands are captured on accept
//   abort              : synchronous flush of the in-flight op
//   ready              : one-cycle pulse, result/flags valid
//   result             : held until the next completion
//   busy               : high while an op is in flight
//   div_by_zero        : completed divide/remainder had rs2 == 0
//   overflow           : completed DIV/REM was MIN_INT / -1
// Multiplies run through MUL_STAGES registers; divides iterate a restoring
// step that retires DIV_BITS_PER_CYCLE bits per cycle on sign magnitudes.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN               = 32,
    parameter int DIV_BITS_PER_CYCLE = 1,
    parameter int MUL_STAGES         = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            valid,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            abort,
    output logic            ready,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            div_by_zero,
    output logic            overflow
);

    localparam int BPC   = DIV_BITS_PER_CYCLE;
    localparam int ITER  = muldiv_iters(XLEN, BPC);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER - 1);
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'((MUL_STAGES > 0) ? MUL_STAGES - 1 : 0);
    localparam logic [XLEN-1:0]  MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

    if ((XLEN % 2) != 0 || XLEN < 8 || !(BPC == 1 || BPC == 2 || BPC == 4) ||
        (XLEN % BPC) != 0 || MUL_STAGES < 0 || MUL_STAGES > 3) begin : g_bad_params
        $error("muldiv_unit: illegal parameter combination");
    end

    muldiv_state_e   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;      // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            is_rem_q, is_rem_d;
    logic            ready_q, ready_d;
    logic            busy_q, busy_d;
    logic            dz_q, dz_d;
    logic            ov_q, ov_d;
    logic [XLEN-1:0] result_q, result_d;

    // Multiplier works straight off the request inputs; the selected half is
    // captured by the stage registers on the accept edge, so later input
    // changes never reach the result.
    logic              a_sgn, b_sgn;
    logic [2*XLEN-1:0] a_ext, b_ext, prod;
    logic [XLEN-1:0]   mul_half, mul_tail;

    assign a_sgn    = (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU);
    assign b_sgn    = (op == MULDIV_OP_MULH);
    assign a_ext    = {{XLEN{a_sgn & rs1[XLEN-1]}}, rs1};
    assign b_ext    = {{XLEN{b_sgn & rs2[XLEN-1]}}, rs2};
    assign prod     = a_ext * b_ext;
    assign mul_half = (op == MULDIV_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    if (MUL_STAGES > 0) begin : g_mul_pipe
        logic [MUL_STAGES-1:0][XLEN-1:0] pipe_q, pipe_d;
        always_comb begin
            pipe_d[0] = mul_half;
            for (int k = 1; k < MUL_STAGES; k++) pipe_d[k] = pipe_q[k-1];
        end
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) pipe_q <= '0;
            else         pipe_q <= pipe_d;
        end
        assign mul_tail = pipe_q[MUL_STAGES-1];
    end else begin : g_mul_comb
        assign mul_tail = mul_half;
    end

    // Divide operand signs: op[0] clear means DIV/REM (signed).
    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] rs1_abs, rs2_abs;
    assign rs1_neg = ~op[0] & rs1[XLEN-1];
    assign rs2_neg = ~op[0] & rs2[XLEN-1];
    assign rs1_abs = rs1_neg ? -rs1 : rs1;
    assign rs2_abs = rs2_neg ? -rs2 : rs2;

    logic [XLEN-1:0] step_rem;
    logic [BPC-1:0]  step_q;

    muldiv_unit_div_radix_step #(.XLEN(XLEN), .BPC(BPC)) u_step (
        .rem_i    (rem_q),
        .bits_i   (quo_q[XLEN-1 -: BPC]),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .q_o      (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        is_rem_d = is_rem_q;
        ready_d  = 1'b0;
        busy_d   = busy_q;
        dz_d     = dz_q;
        ov_d     = ov_q;
        result_d = result_q;

        if (abort) begin
            // Flush wins everywhere; result and flags are left untouched.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (valid) begin
                    busy_d   = 1'b1;
                    dz_d     = 1'b0;
                    ov_d     = 1'b0;
                    cnt_d    = '0;
                    is_rem_d = op[1];
                    if (!op[2]) begin
                        if (MUL_STAGES == 0) begin
                            state_d  = ST_DONE;
                            ready_d  = 1'b1;
                            busy_d   = 1'b0;
                            result_d = mul_tail;
                        end else begin
                            state_d = ST_MUL;
                        end
                    end else if (rs2 == '0) begin
                        state_d  = ST_DONE;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                        dz_d     = 1'b1;
                        result_d = op[1] ? rs1 : '1;
                    end else if (!op[0] && rs1 == MIN_INT && rs2 == '1) begin
                        state_d  = ST_DONE;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                        ov_d     = 1'b1;
                        result_d = op[1] ? '0 : MIN_INT;
                    end else begin
                        state_d = ST_DIV_ITER;
                        quo_d   = rs1_abs;
                        rem_d   = '0;
                        dvs_d   = rs2_abs;
                        q_neg_d = rs1_neg ^ rs2_neg;
                        r_neg_d = rs1_neg;
                    end
                end
                ST_MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        state_d  = ST_DONE;
                        ready_d  = 1'b1;
                        busy_d   = 1'b0;
                        result_d = mul_tail;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DIV_ITER: begin
                    rem_d = step_rem;
                    quo_d = {quo_q[XLEN-BPC-1:0], step_q};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ITER_LAST) state_d = ST_DIV_FIX;
                end
                ST_DIV_FIX: begin
                    state_d  = ST_DONE;
                    ready_d  = 1'b1;
                    busy_d   = 1'b0;
                    result_d = is_rem_q ? (r_neg_q ? -rem_q : rem_q)
                                        : (q_neg_q ? -quo_q : quo_q);
                end
                ST_DONE:     state_d = ST_WAIT_LOW;
                // A request held past ready must drop before the next accept.
                ST_WAIT_LOW: if (!valid) state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            dz_q     <= 1'b0;
            ov_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_rem_q <= is_rem_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            dz_q     <= dz_d;
            ov_q     <= ov_d;
            result_q <= result_d;
        end
    end

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;
    assign result      = result_q;

endmodule
